// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: instruction in (valid/ready), ALU write-back strobe, registered bundle out (valid/ready).
// slave = operand_fetch side, master = upstream issue/ALU side.
interface operand_fetch_if #(
    parameter int BITS = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [BITS-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [BITS-1:0] out_a;
    logic [BITS-1:0] out_b;
    logic [4:0]      out_rd;

    modport slave (
        input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_instr, out_a, out_b, out_rd
    );

    modport master (
        output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_instr, out_a, out_b, out_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// RV32I operand fetch with busy-register scoreboard; 1-cycle issue latency, stalls on hazard or held output.
// Option OPERAND_FETCH_WB_BYPASS_EN: forward same-cycle write-back to sources and lift the stall a cycle early.
module operand_fetch #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  bus
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic [BITS-1:0] regs [32];
    logic [31:0]     busy;
    logic [31:0]     blk;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            is_r;
    logic            is_i;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            wb_live;
    logic [BITS-1:0] imm;
    logic [BITS-1:0] rs1_val;
    logic [BITS-1:0] rs2_val;
    logic [BITS-1:0] b_val;
    logic            hazard;
    logic            ready;
    logic            issue;

    logic            out_valid_q;
    logic [31:0]     out_instr_q;
    logic [BITS-1:0] out_a_q;
    logic [BITS-1:0] out_b_q;
    logic [4:0]      out_rd_q;

    assign opcode  = bus.in_instr[6:0];
    assign rd      = bus.in_instr[11:7];
    assign rs1     = bus.in_instr[19:15];
    assign rs2     = bus.in_instr[24:20];
    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign use_rs1 = is_r | is_i;
    assign use_rs2 = is_r;
    assign wr_rd   = (is_r | is_i) & (rd != 5'd0);
    assign wb_live = bus.wb_en & (bus.wb_rd != 5'd0);
    assign imm     = {{(BITS-12){bus.in_instr[31]}}, bus.in_instr[31:20]};

    always_comb begin
        blk = busy;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_live) begin
            blk[bus.wb_rd] = 1'b0;
        end
`endif
    end

    // x0 is forced to zero here rather than trusting the array contents.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_live && (bus.wb_rd == rs1)) begin
            rs1_val = bus.wb_data;
        end
        if (wb_live && (bus.wb_rd == rs2)) begin
            rs2_val = bus.wb_data;
        end
`endif
    end

    assign b_val  = is_i ? imm : rs2_val;
    assign hazard = (use_rs1 & blk[rs1]) | (use_rs2 & blk[rs2]) | (wr_rd & blk[rd]);
    assign ready  = (~out_valid_q | bus.out_ready) & ~hazard;
    assign issue  = bus.in_valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            busy        <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (issue) begin
                out_valid_q <= 1'b1;
                out_instr_q <= bus.in_instr;
                out_a_q     <= rs1_val;
                out_b_q     <= b_val;
                out_rd_q    <= wr_rd ? rd : 5'd0;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (wb_live) begin
                regs[bus.wb_rd] <= bus.wb_data;
                busy[bus.wb_rd] <= 1'b0;
            end
            // Later assignment wins: a same-edge issue re-claims the register being released.
            if (issue && wr_rd) begin
                busy[rd] <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_rd    = out_rd_q;
endmodule
